// File: rtl/pairhmm_pkg.sv
// Shared types for the pairhmm datapath blocks.
package pairhmm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DONE = 2'd2
    } transfer_state_t;

    localparam int DEFAULT_COUNT_WIDTH = 16;

endpackage

// File: rtl/fifo_if.sv
// FIFO port bundle: read side expects a first-word-fall-through source, write side a sink with full.
interface fifo_if #(parameter type T = logic) ();

    logic read;
    T     read_data;
    logic empty;
    logic write;
    T     write_data;
    logic full;

    modport master_read  (output read,  input  read_data, input  empty);
    modport slave_read   (input  read,  output read_data, output empty);
    modport master_write (output write, output write_data, input full);
    modport slave_write  (input  write, input  write_data, output full);

endinterface

// File: rtl/cl_transfer_stage.sv
// Single-entry holding register between source and sink; one cycle of latency.
// Load wins over unload so a simultaneous read/write keeps the stage full.
module cl_transfer_stage #(
    parameter type T = logic
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic load,
    input  T     load_data,
    input  logic unload,
    output logic valid,
    output T     data
);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

    // Payload only matters while valid is set, so it carries no reset.
    always_ff @(posedge clock_i) begin
        if (load) begin
            data <= load_data;
        end
    end

endmodule

// File: rtl/cl_fifo_transfer_master.sv
// Moves length_i elements from an FWFT source to a sink through one output stage.
// One element per cycle when unblocked; stalls on source empty or sink full.
module cl_fifo_transfer_master
    import pairhmm_pkg::*;
#(
    parameter type T           = logic,
    parameter int  COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic [COUNT_WIDTH-1:0] length_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [COUNT_WIDTH-1:0] count_o,
    fifo_if.master_read            read_bus,
    fifo_if.master_write           write_bus
);

    transfer_state_t        state;
    transfer_state_t        state_next;
    logic [COUNT_WIDTH-1:0] length_q;
    logic [COUNT_WIDTH-1:0] rd_cnt;
    logic                   stage_valid;
    T                       stage_data;
    logic                   rd;
    logic                   wr;
    logic                   accept;
    logic                   last_write;

    assign accept     = (state == IDLE) && start_i;
    assign wr         = stage_valid && !write_bus.full;
    assign rd         = (state == MOVE) && !read_bus.empty && (rd_cnt < length_q)
                        && (!stage_valid || wr);
    assign last_write = wr && ((count_o + COUNT_WIDTH'(1)) == length_q);

    assign read_bus.read        = rd;
    assign write_bus.write      = wr;
    assign write_bus.write_data = stage_data;

    cl_transfer_stage #(.T(T)) u_stage (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .load      (rd),
        .load_data (read_bus.read_data),
        .unload    (wr),
        .valid     (stage_valid),
        .data      (stage_data)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = (length_i == '0) ? DONE : MOVE;
                end
            end
            MOVE: begin
                busy_o = 1'b1;
                if (last_write) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // count_o keeps the final tally until the next accepted start.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            length_q <= '0;
            rd_cnt   <= '0;
            count_o  <= '0;
        end else if (accept) begin
            length_q <= length_i;
            rd_cnt   <= '0;
            count_o  <= '0;
        end else begin
            if (rd) begin
                rd_cnt <= rd_cnt + COUNT_WIDTH'(1);
            end
            if (wr) begin
                count_o <= count_o + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_cl_fifo_transfer_master.sv
// Randomized bench: queue-based source/sink model checks data order, counts and timing.
module tb_cl_fifo_transfer_master;

    localparam int CW = 16;
    typedef logic [7:0] data_t;

    logic          clock_i = 1'b0;
    logic          reset_i;
    logic          start_i;
    logic [CW-1:0] length_i;
    logic          busy_o;
    logic          done_o;
    logic [CW-1:0] count_o;

    fifo_if #(.T(data_t)) read_bus ();
    fifo_if #(.T(data_t)) write_bus ();

    cl_fifo_transfer_master #(.T(data_t), .COUNT_WIDTH(CW)) dut (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .start_i   (start_i),
        .length_i  (length_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .count_o   (count_o),
        .read_bus  (read_bus),
        .write_bus (write_bus)
    );

    always #5 clock_i = ~clock_i;

    int    n_checks = 0;
    int    n_fail   = 0;
    data_t src[$];
    data_t snk[$];
    int    t, reads, writes, dones, occ, max_occ, viol_rd, viol_wr;
    int    first_rd_t, first_wr_t, last_wr_t, done_t, hold_left, full_mode;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) src.push_back(data_t'($urandom));
    endtask

    task automatic reset_stats();
        snk = {};
        t = 0; reads = 0; writes = 0; dones = 0; occ = 0; max_occ = 0;
        viol_rd = 0; viol_wr = 0;
        first_rd_t = -1; first_wr_t = -1; last_wr_t = -1; done_t = -1;
    endtask

    task automatic drive_inputs();
        read_bus.empty     = (hold_left > 0) || (src.size() == 0);
        read_bus.read_data = (src.size() > 0) ? src[0] : 8'h00;
        case (full_mode)
            1:       write_bus.full = t[0];
            2:       write_bus.full = 1'($urandom_range(0, 1));
            default: write_bus.full = 1'b0;
        endcase
    endtask

    // One clock: present inputs, sample the handshake mid-cycle, then apply it to the model.
    task automatic cycle();
        logic  rd, wr, dn;
        data_t wd;
        drive_inputs();
        @(negedge clock_i);
        rd = read_bus.read;
        wr = write_bus.write;
        wd = write_bus.write_data;
        dn = done_o;
        if (rd && read_bus.empty) viol_rd++;
        if (wr && write_bus.full) viol_wr++;
        @(posedge clock_i);
        #1;
        if (rd) begin
            if (src.size() > 0) void'(src.pop_front());
            reads++;
            if (first_rd_t < 0) first_rd_t = t;
        end
        if (wr) begin
            snk.push_back(wd);
            writes++;
            if (first_wr_t < 0) first_wr_t = t;
            last_wr_t = t;
        end
        occ = occ + int'(rd) - int'(wr);
        if (occ > max_occ) max_occ = occ;
        if (dn) begin
            dones++;
            done_t = t;
        end
        if (hold_left > 0) hold_left--;
        t++;
    endtask

    task automatic xfer(input int len, input int hold, input int fmode,
                        input int restart_at, input int abort_after);
        data_t exp_q[$];
        int    pre;
        int    budget;
        exp_q = {};
        for (int i = 0; i < len && i < src.size(); i++) exp_q.push_back(src[i]);
        pre       = src.size();
        budget    = 300;
        reset_stats();
        hold_left = hold;
        full_mode = fmode;
        start_i   = 1'b1;
        length_i  = CW'(len);
        cycle();
        start_i   = 1'b0;
        while (dones == 0 && budget > 0) begin
            if (abort_after > 0 && writes >= abort_after) return;
            start_i  = (t == restart_at);
            length_i = start_i ? CW'(9) : CW'($urandom);
            cycle();
            start_i  = 1'b0;
            budget--;
        end
        repeat (2) begin
            length_i = CW'($urandom);
            cycle();
        end
        check_eq("done_pulses", dones, 1);
        check_eq("writes", writes, len);
        check_eq("reads", reads, len);
        for (int i = 0; i < exp_q.size(); i++)
            check_eq("data", (i < snk.size()) ? 64'(snk[i]) : 64'hFFFF, exp_q[i]);
        check_eq("count_hold", count_o, len);
        check_eq("src_left", src.size(), pre - len);
        check_eq("read_when_empty", viol_rd, 0);
        check_eq("write_when_full", viol_wr, 0);
        check_eq("stage_le_one", max_occ <= 1, 1);
        check_eq("busy_idle", busy_o, 0);
        if (len > 0) check_eq("done_after_last_write", done_t, last_wr_t + 1);
        else         check_eq("done_len0", done_t, 1);
        if (fmode == 0 && len > 0) begin
            check_eq("first_read_t", first_rd_t, (hold > 1) ? hold : 1);
            check_eq("read_to_write", first_wr_t, first_rd_t + 1);
            check_eq("back_to_back", last_wr_t - first_wr_t, len - 1);
        end
    endtask

    initial begin
        reset_i   = 1'b1;
        start_i   = 1'b0;
        length_i  = '0;
        full_mode = 0;
        hold_left = 0;
        t         = 0;
        read_bus.write       = 1'b0;
        read_bus.write_data  = 8'h00;
        read_bus.full        = 1'b0;
        write_bus.read       = 1'b0;
        write_bus.read_data  = 8'h00;
        write_bus.empty      = 1'b1;
        fill(4);
        drive_inputs();
        #12;
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_done", done_o, 0);
        check_eq("rst_count", count_o, 0);
        check_eq("rst_read", read_bus.read, 0);
        check_eq("rst_write", write_bus.write, 0);
        @(posedge clock_i);
        #1 reset_i = 1'b0;

        xfer(4, 0, 0, -1, 0);
        fill(2);
        xfer(0, 0, 0, -1, 0);
        fill(1);
        xfer(3, 5, 0, -1, 0);
        fill(8);
        xfer(6, 0, 1, -1, 0);

        // Reset in the middle of an 8-element transfer.
        src = {};
        fill(8);
        xfer(8, 0, 0, -1, 3);
        check_eq("pre_rst_count", count_o, 3);
        #2 reset_i = 1'b1;
        #1;
        check_eq("mid_rst_busy", busy_o, 0);
        check_eq("mid_rst_done", done_o, 0);
        check_eq("mid_rst_count", count_o, 0);
        check_eq("mid_rst_read", read_bus.read, 0);
        check_eq("mid_rst_write", write_bus.write, 0);
        @(posedge clock_i);
        #1 reset_i = 1'b0;
        reset_stats();
        hold_left = 0;
        full_mode = 0;
        repeat (5) cycle();
        check_eq("post_rst_writes", writes, 0);
        check_eq("post_rst_reads", reads, 0);
        xfer(2, 0, 0, -1, 0);

        fill(12);
        xfer(5, 0, 0, 2, 0);

        for (int k = 0; k < 6; k++) begin
            int len;
            len = $urandom_range(0, 10);
            src = {};
            fill(len + $urandom_range(0, 3));
            xfer(len, $urandom_range(0, 4), $urandom_range(0, 2), -1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
